// File: rtl/bcd_convert_scheduler.sv
// Two-requester binary-to-BCD converter: round-robin arbitration in front of a
// shared double-dabble engine that retires one input bit per clock.
module bcd_convert_scheduler #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  req0,
    input  logic [WIDTH-1:0]      value0,
    input  logic                  req1,
    input  logic [WIDTH-1:0]      value1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  src_id,
    output logic                  valid
);

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t                state_q;
    logic [WIDTH-1:0]      shift_q;
    logic [4*DIGITS-1:0]   acc_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  grant_id_q;
    logic                  last_grant_q;

    logic [4*DIGITS-1:0]   acc_adj;
    logic [4*DIGITS-1:0]   acc_d;
    logic                  grant0;
    logic                  grant1;

    // Add-3 correction is per digit with no carry between digits.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ?
                                        acc_q[4*gi +: 4] + 4'd3 :
                                        acc_q[4*gi +: 4];
        end
    endgenerate

    assign acc_d = {acc_adj[4*DIGITS-2:0], shift_q[WIDTH-1]};

    // On a tie the requester that did not win last time is served.
    assign grant0 = req0 && (!req1 || last_grant_q);
    assign grant1 = req1 && (!req0 || !last_grant_q);

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            busy         <= 1'b0;
            valid        <= 1'b0;
            bcd_out      <= '0;
            src_id       <= 1'b0;
        end else begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant0 || grant1) begin
                        shift_q      <= grant1 ? value1 : value0;
                        acc_q        <= '0;
                        cnt_q        <= '0;
                        grant_id_q   <= grant1;
                        last_grant_q <= grant1;
                        ack0         <= grant0;
                        ack1         <= grant1;
                        busy         <= 1'b1;
                        state_q      <= CONVERT;
                    end
                end
                CONVERT: begin
                    acc_q   <= acc_d;
                    shift_q <= shift_q << 1;
                    cnt_q   <= cnt_q + 1'b1;
                    // Result is published only once complete, never mid-conversion.
                    if (cnt_q == LAST_CNT) begin
                        bcd_out <= acc_d;
                        src_id  <= grant_id_q;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
